// File: rtl/layer_weight_sequencer.sv
// Purpose: fetches each layer's weights from memory into the weight buffer and hands layers to the pipeline controller.
// Latency: WORDS_PER_LAYER+2 cycles from FETCH entry to DRAIN entry; buffer writes trail memory reads by 1 cycle.
// Backpressure: pipe_busy holds the sequencer in DRAIN; run is ignored while busy.
module layer_weight_sequencer #(
  parameter int NUM_LAYERS      = 4,
  parameter int WORDS_PER_LAYER = 8,
  parameter int WADDR_W         = 3,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 16,
  localparam int LIDX_W         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                wbuf_wr_en,
  output logic [WADDR_W-1:0]  wbuf_wr_addr,
  output logic [DATA_W-1:0]   wbuf_wr_data,
  output logic                start,
  output logic                layer_ready,
  input  logic                pipe_busy,
  output logic [LIDX_W-1:0]   layer_idx,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_READY,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [WADDR_W-1:0] LAST_WORD  = WADDR_W'(WORDS_PER_LAYER - 1);
  localparam logic [LIDX_W-1:0]  LAST_LAYER = LIDX_W'(NUM_LAYERS - 1);
  localparam logic [ADDR_W-1:0]  WORDS_A    = ADDR_W'(WORDS_PER_LAYER);

  state_t             state;
  logic [WADDR_W-1:0] rd_cnt;
  logic [LIDX_W-1:0]  next_layer;

  assign next_layer = layer_idx + LIDX_W'(1);

  // Memory data lands one cycle after the read strobe, so it goes straight to the buffer.
  assign wbuf_wr_data = mem_rd_data;

  // Sequencer FSM; all handshake outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rd_cnt      <= '0;
      layer_idx   <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      start       <= 1'b0;
      layer_ready <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state     <= S_FETCH;
            layer_idx <= '0;
            rd_cnt    <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= '0;
            start     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          // start only marks the first fetch cycle of a layer
          start <= 1'b0;
          if (rd_cnt == LAST_WORD) begin
            rd_cnt    <= '0;
            mem_rd_en <= 1'b0;
            state     <= S_FLUSH;
          end else begin
            rd_cnt   <= rd_cnt + WADDR_W'(1);
            mem_addr <= mem_addr + ADDR_W'(1);
          end
        end
        S_FLUSH: begin
          // the last word is written this cycle, so the layer is complete next cycle
          layer_ready <= 1'b1;
          state       <= S_READY;
        end
        S_READY: begin
          layer_ready <= 1'b0;
          state       <= S_DRAIN;
        end
        S_DRAIN: begin
          // controller already raised busy one cycle after start, so no guard cycle here
          if (!pipe_busy) begin
            if (layer_idx == LAST_LAYER) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              layer_idx <= next_layer;
              rd_cnt    <= '0;
              mem_rd_en <= 1'b1;
              mem_addr  <= ADDR_W'(next_layer) * WORDS_A;
              start     <= 1'b1;
              state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          mem_rd_en   <= 1'b0;
          start       <= 1'b0;
          layer_ready <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

  // Buffer write strobe and address trail the read strobe and read index by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_wr_en   <= 1'b0;
      wbuf_wr_addr <= '0;
    end else begin
      wbuf_wr_en   <= mem_rd_en;
      wbuf_wr_addr <= rd_cnt;
    end
  end

endmodule

// File: tb/tb_layer_weight_sequencer.sv
`timescale 1ns/1ps
module tb_layer_weight_sequencer;

  localparam int NL = 4, WL = 8, WA = 3, AW = 8, DW = 16;
  localparam int HIST = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default-configuration DUT
  logic          run = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          wbuf_wr_en;
  logic [WA-1:0] wbuf_wr_addr;
  logic [DW-1:0] wbuf_wr_data;
  logic          start, layer_ready, busy, done;
  logic          pipe_busy;
  logic [1:0]    layer_idx;

  layer_weight_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .wbuf_wr_en(wbuf_wr_en), .wbuf_wr_addr(wbuf_wr_addr), .wbuf_wr_data(wbuf_wr_data),
    .start(start), .layer_ready(layer_ready), .pipe_busy(pipe_busy),
    .layer_idx(layer_idx), .busy(busy), .done(done)
  );

  // single-layer, single-word DUT
  logic          run1 = 1'b0;
  logic          rd_en1;
  logic [3:0]    addr1;
  logic [DW-1:0] rdata1 = '0;
  logic          wr_en1;
  logic [0:0]    wr_addr1;
  logic [DW-1:0] wr_data1;
  logic          start1, ready1, busy1, done1;
  logic          pb1 = 1'b0;
  logic [0:0]    lidx1;
  logic [DW-1:0] mem1_word;

  layer_weight_sequencer #(.NUM_LAYERS(1), .WORDS_PER_LAYER(1), .WADDR_W(1), .ADDR_W(4), .DATA_W(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run1),
    .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(rdata1),
    .wbuf_wr_en(wr_en1), .wbuf_wr_addr(wr_addr1), .wbuf_wr_data(wr_data1),
    .start(start1), .layer_ready(ready1), .pipe_busy(pb1),
    .layer_idx(lidx1), .busy(busy1), .done(done1)
  );

  // synchronous weight memories: data one cycle after the strobe
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  always @(posedge clk) if (rd_en1) rdata1 <= mem1_word;

  // pipeline controller model: busy from the cycle after start until drain_len cycles after layer_ready
  int drain_len [0:NL-1];
  logic [1:0] ph;
  int cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_busy <= 1'b0; ph <= 2'd0; cnt <= 0;
    end else if (start) begin
      pipe_busy <= 1'b1; ph <= 2'd1;
    end else if (ph == 2'd1 && layer_ready) begin
      ph <= 2'd2; cnt <= drain_len[layer_idx];
    end else if (ph == 2'd2) begin
      if (cnt <= 1) begin pipe_busy <= 1'b0; ph <= 2'd0; end
      else cnt <= cnt - 1;
    end
  end

  // event log, sampled mid-cycle
  typedef struct { int cyc; int a; int d; } ev_t;
  ev_t rd_q[$];
  ev_t wr_q[$];
  int start_q[$], startl_q[$], ready_q[$], done_q[$];
  int cyc = 0;
  int mux_err = 0;
  logic pb_hist [0:HIST-1];
  logic busy_hist [0:HIST-1];
  int lidx_hist [0:HIST-1];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HIST) begin
      pb_hist[cyc]   <= pipe_busy;
      busy_hist[cyc] <= busy;
      lidx_hist[cyc] <= int'(layer_idx);
    end
    if (mem_rd_en === 1'b1) rd_q.push_back('{cyc, int'(mem_addr), 0});
    if (wbuf_wr_en === 1'b1) wr_q.push_back('{cyc, int'(wbuf_wr_addr), int'(wbuf_wr_data)});
    if (start === 1'b1) begin start_q.push_back(cyc); startl_q.push_back(int'(layer_idx)); end
    if (layer_ready === 1'b1) ready_q.push_back(cyc);
    if (done === 1'b1) done_q.push_back(cyc);
    if ((int'(start) + int'(layer_ready) + int'(done)) > 1) mux_err <= mux_err + 1;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete(); wr_q.delete(); start_q.delete(); startl_q.delete();
    ready_q.delete(); done_q.delete();
  endtask

  // expected pass timeline derived from the layer rules and the logged pipe_busy
  task automatic check_pass(input string tag, input int r);
    int s, c, k, bad;
    s = r + 1;
    check({tag, "/n_start"}, start_q.size(), NL);
    check({tag, "/n_ready"}, ready_q.size(), NL);
    check({tag, "/n_rd"},    rd_q.size(), NL * WL);
    check({tag, "/n_wr"},    wr_q.size(), NL * WL);
    check({tag, "/n_done"},  done_q.size(), 1);
    check({tag, "/idle_before"}, busy_hist[r], 1'b0);
    for (int L = 0; L < NL; L++) begin
      if (L < start_q.size()) begin
        check($sformatf("%s/start_cyc_L%0d", tag, L), start_q[L], s);
        check($sformatf("%s/start_lidx_L%0d", tag, L), startl_q[L], L);
      end
      for (int i = 0; i < WL; i++) begin
        k = L * WL + i;
        if (k < rd_q.size())
          check($sformatf("%s/rd_L%0d_w%0d", tag, L, i),
                {32'(rd_q[k].cyc), 16'(rd_q[k].a), 16'h0}, {32'(s + i), 16'(k), 16'h0});
        if (k < wr_q.size())
          check($sformatf("%s/wr_L%0d_w%0d", tag, L, i),
                {32'(wr_q[k].cyc), 16'(wr_q[k].a), 16'(wr_q[k].d)}, {32'(s + i + 1), 16'(i), mem[k]});
      end
      if (L < ready_q.size())
        check($sformatf("%s/ready_cyc_L%0d", tag, L), ready_q[L], s + WL + 1);
      c = s + WL + 2;
      while (c < HIST - 2 && pb_hist[c] !== 1'b0) c++;
      bad = 0;
      for (int t = s; t <= c; t++) if (lidx_hist[t] != L) bad++;
      check($sformatf("%s/lidx_hold_L%0d", tag, L), bad, 0);
      if (L < NL - 1) s = c + 1;
      else begin
        if (done_q.size() > 0) check({tag, "/done_cyc"}, done_q[0], c + 1);
        bad = 0;
        for (int t = r + 1; t <= c + 1; t++) if (busy_hist[t] !== 1'b1) bad++;
        check({tag, "/busy_window"}, bad, 0);
        check({tag, "/idle_after"}, busy_hist[c + 2], 1'b0);
      end
    end
  endtask

  task automatic run_pass(input string tag, input bit repulse);
    int r, t;
    bit pulsed;
    pulsed = 1'b0;
    clear_log();
    @(posedge clk); #1; run = 1'b1; r = cyc;
    @(posedge clk); #1; run = 1'b0;
    t = 0;
    while (done_q.size() == 0 && t < 2000) begin
      @(posedge clk); #1; t++;
      run = 1'b0;
      if (repulse && !pulsed && layer_idx == 2'd2 && mem_rd_en) begin run = 1'b1; pulsed = 1'b1; end
    end
    run = 1'b0;
    check({tag, "/done_seen"}, done_q.size() > 0, 1'b1);
    if (repulse) check({tag, "/repulse_applied"}, pulsed, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    check_pass(tag, r);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
    for (int l = 0; l < NL; l++) drain_len[l] = int'($urandom_range(1, 6));
  endtask

  initial begin
    int nrd, nwr, nst, t;
    for (int a = 0; a < 256; a++) mem[a] = DW'(a);
    for (int l = 0; l < NL; l++) drain_len[l] = 3;
    mem1_word = '0;

    // reset held for 3 cycles, then idle with run low
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset/outputs", {mem_rd_en, start, layer_ready, done, busy, wbuf_wr_en, layer_idx, mem_addr}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle/outputs_c%0d", i),
            {mem_rd_en, start, layer_ready, done, busy, wbuf_wr_en, layer_idx, mem_addr,
             rd_en1, start1, ready1, done1, busy1, wr_en1}, '0);
    end

    // single pass, word[a]=a, 3-cycle controller drain
    run_pass("passA", 1'b0);

    // layer 1 held in drain for 20 cycles
    fill_random();
    drain_len[1] = 20;
    run_pass("long_drain", 1'b0);

    // run re-pulsed during layer 2 fetch
    fill_random();
    run_pass("repulse", 1'b1);

    // asynchronous reset in the rd_cnt=5 fetch cycle
    fill_random();
    clear_log();
    @(posedge clk); #1; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    t = 0;
    @(negedge clk);
    while (!(mem_rd_en === 1'b1 && mem_addr == 8'd5) && t < 50) begin @(negedge clk); t++; end
    check("midreset/reached_rd5", {mem_rd_en, mem_addr}, {1'b1, 8'd5});
    #1 rst_n = 1'b0;
    #1;
    check("midreset/outputs_now",
          {mem_rd_en, start, layer_ready, done, busy, wbuf_wr_en, wbuf_wr_addr, layer_idx, mem_addr}, '0);
    nrd = rd_q.size(); nwr = wr_q.size(); nst = start_q.size();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midreset/no_more_writes", wr_q.size(), nwr);
    check("midreset/no_more_reads", rd_q.size(), nrd);
    check("midreset/no_more_starts", start_q.size(), nst);
    check("midreset/stays_idle", busy, 1'b0);

    // fresh pass after the abandoned one
    run_pass("after_reset", 1'b0);

    // mutual exclusion of start/layer_ready/done over all passes
    check("mutex/start_ready_done", mux_err, 0);

    // one layer of one word
    mem1_word = DW'($urandom);
    @(posedge clk); #1; run1 = 1'b1;
    @(posedge clk); #1; run1 = 1'b0; pb1 = 1'b1;
    @(negedge clk);
    check("n1/start_and_read", {start1, rd_en1, busy1, addr1}, {1'b1, 1'b1, 1'b1, 4'd0});
    @(negedge clk);
    check("n1/write", {wr_en1, wr_addr1, wr_data1, ready1, rd_en1}, {1'b1, 1'b0, mem1_word, 1'b0, 1'b0});
    @(negedge clk);
    check("n1/ready", {ready1, wr_en1, start1}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("n1/drain_hold_%0d", i), {done1, start1, ready1, busy1}, {1'b0, 1'b0, 1'b0, 1'b1});
    end
    @(posedge clk); #1; pb1 = 1'b0;
    @(negedge clk);
    check("n1/no_done_yet", done1, 1'b0);
    @(negedge clk);
    check("n1/done", {done1, busy1}, {1'b1, 1'b1});
    @(negedge clk);
    check("n1/idle", {done1, busy1, start1, rd_en1}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
